// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

  // Scan states: dark inter-digit gap, or one digit slot being shown.
  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  // Slot counter width: wide enough for the longer of the lit and gap phases.
  function automatic int cnt_width(input int on_cycles, input int gap_cycles);
    int m;
    m = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seven_seg_lz_blank.sv
// Per-digit dark vector: explicit mask plus optional leading-zero suppression.
module seven_seg_lz_blank #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  input  logic                    i_lz_suppress,
  output logic [NUM_DIGITS-1:0]   o_blank
);

  // w_zero_from[k] = 1 when nibbles k..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS-1:1] w_zero_from;

  for (genvar k = NUM_DIGITS - 1; k >= 1; k--) begin : g_zero
    if (k == NUM_DIGITS - 1) begin : g_top
      assign w_zero_from[k] = (i_value[4*k +: 4] == 4'h0);
    end else begin : g_mid
      assign w_zero_from[k] = w_zero_from[k+1] & (i_value[4*k +: 4] == 4'h0);
    end
    assign o_blank[k] = i_blank_mask[k] | (i_lz_suppress & w_zero_from[k]);
  end

  // Digit 0 always shows something unless explicitly masked.
  assign o_blank[0] = i_blank_mask[0];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing
// one hex decoder. Outputs are active-low and registered.
//
//   state   | meaning
//   ST_GAP  | all anodes off for GAP_CYCLES; exit boundary loads pending data
//   ST_SHOW | digit r_idx driven for ON_CYCLES, then index advances
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ON_CYCLES  = 50000,
  parameter int GAP_CYCLES = 500
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_blank_mask,
  input  logic                    i_lz_suppress,
  output logic [3:0]              o_hex_n,
  output logic [NUM_DIGITS-1:0]   o_digit_n,
  output logic                    o_frame
);

  localparam int CW = cnt_width(ON_CYCLES, GAP_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  state_e                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;

  logic [4*NUM_DIGITS-1:0] r_pend_value;
  logic [NUM_DIGITS-1:0]   r_pend_mask;
  logic                    r_pend_lz;
  logic                    r_pend_valid;

  logic [4*NUM_DIGITS-1:0] r_act_value;
  logic [NUM_DIGITS-1:0]   r_act_mask;
  logic                    r_act_lz;

  logic [3:0]              r_hex_n;
  logic [NUM_DIGITS-1:0]   r_digit_n;
  logic                    r_frame;

  state_e                  w_state_nxt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [IW-1:0]           w_idx_nxt;
  logic                    w_take;
  logic                    w_frame_nxt;
  logic [4*NUM_DIGITS-1:0] w_act_value_nxt;
  logic [NUM_DIGITS-1:0]   w_act_mask_nxt;
  logic                    w_act_lz_nxt;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_hex_n_nxt;
  logic [NUM_DIGITS-1:0]   w_digit_n_nxt;

  // Next-state, slot counter and boundary decisions.
  // With GAP_CYCLES=0 the gap is only visited once, right after reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_take      = 1'b0;
    w_frame_nxt = 1'b0;
    case (r_state)
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
          w_take      = r_pend_valid;
        end
      end
      ST_SHOW: begin
        if (r_cnt == ON_LAST) begin
          w_state_nxt = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          w_frame_nxt = (r_idx == IDX_LAST);
          if (GAP_CYCLES == 0) w_take = r_pend_valid;
        end
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Active display data only changes at a slot boundary, so a slot never tears.
  always_comb begin
    w_act_value_nxt = w_take ? r_pend_value : r_act_value;
    w_act_mask_nxt  = w_take ? r_pend_mask  : r_act_mask;
    w_act_lz_nxt    = w_take ? r_pend_lz    : r_act_lz;
  end

  seven_seg_lz_blank #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_blank (
    .i_value       (w_act_value_nxt),
    .i_blank_mask  (w_act_mask_nxt),
    .i_lz_suppress (w_act_lz_nxt),
    .o_blank       (w_blank)
  );

  // Output pattern for the upcoming cycle; registered below so pins are glitch-free.
  always_comb begin
    w_hex_n_nxt   = 4'hF;
    w_digit_n_nxt = '1;
    if (w_state_nxt == ST_SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (w_idx_nxt == IW'(k)) begin
          w_hex_n_nxt      = ~w_act_value_nxt[4*k +: 4];
          w_digit_n_nxt[k] = w_blank[k];
        end
      end
    end
  end

  // State, counter and index registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_GAP;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Pending/active data; a LOAD on the take edge re-arms pending for the next slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_value <= '0;
      r_pend_mask  <= '0;
      r_pend_lz    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_act_value  <= '0;
      r_act_mask   <= '0;
      r_act_lz     <= 1'b0;
    end else begin
      r_act_value <= w_act_value_nxt;
      r_act_mask  <= w_act_mask_nxt;
      r_act_lz    <= w_act_lz_nxt;
      if (i_load) begin
        r_pend_value <= i_value;
        r_pend_mask  <= i_blank_mask;
        r_pend_lz    <= i_lz_suppress;
        r_pend_valid <= 1'b1;
      end else if (w_take) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hex_n   <= 4'hF;
      r_digit_n <= '1;
      r_frame   <= 1'b0;
    end else begin
      r_hex_n   <= w_hex_n_nxt;
      r_digit_n <= w_digit_n_nxt;
      r_frame   <= w_frame_nxt;
    end
  end

  assign o_hex_n   = r_hex_n;
  assign o_digit_n = r_digit_n;
  assign o_frame   = r_frame;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: one build with a 1-cycle gap and one with no
// gap, both driven by the same inputs and checked against a timing model that
// derives slot position directly from the cycle count since reset.
module tb_seven_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int ON = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   value;
  logic          load;
  logic [3:0]    mask;
  logic          lz;

  logic [3:0]    hex_g, hex_z;
  logic [3:0]    dig_g, dig_z;
  logic          frm_g, frm_z;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state, index 0 = gap build, index 1 = no-gap build.
  int          m_t    [2];
  logic [15:0] m_pval [2];
  logic [3:0]  m_pmask[2];
  logic        m_plz  [2];
  logic        m_pv   [2];
  logic [15:0] m_aval [2];
  logic [3:0]  m_amask[2];
  logic        m_alz  [2];

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(ON), .GAP_CYCLES(1)) u_dut_g (
    .i_clk(clk), .i_reset(rst), .i_value(value), .i_load(load),
    .i_blank_mask(mask), .i_lz_suppress(lz),
    .o_hex_n(hex_g), .o_digit_n(dig_g), .o_frame(frm_g)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(ON), .GAP_CYCLES(0)) u_dut_z (
    .i_clk(clk), .i_reset(rst), .i_value(value), .i_load(load),
    .i_blank_mask(mask), .i_lz_suppress(lz),
    .o_hex_n(hex_z), .o_digit_n(dig_z), .o_frame(frm_z)
  );

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  // t counts cycles since the reset edge; t=0 is the post-reset gap cycle.
  function automatic bit is_show(input int g, input int t);
    if (g > 0) return (t % (ON + g)) >= g;
    return t >= 1;
  endfunction

  function automatic int digit_of(input int g, input int t);
    if (g > 0) return (t / (ON + g)) % N;
    return ((t - 1) / ON) % N;
  endfunction

  function automatic bit slot_start(input int g, input int t);
    if (!is_show(g, t)) return 1'b0;
    if (g > 0) return (t % (ON + g)) == g;
    return ((t - 1) % ON) == 0;
  endfunction

  function automatic bit frame_at(input int g, input int t);
    if (g > 0) return (t > 0) && (t % (ON + g) == 0) && ((t / (ON + g)) % N == 0);
    return (t > 1) && ((t - 1) % (ON * N) == 0);
  endfunction

  task automatic model_edge(input int k);
    if (rst) begin
      m_t[k] = 0;
      m_pval[k] = '0; m_pmask[k] = '0; m_plz[k] = 1'b0; m_pv[k] = 1'b0;
      m_aval[k] = '0; m_amask[k] = '0; m_alz[k] = 1'b0;
    end else begin
      m_t[k]++;
      if (slot_start(gap_of(k), m_t[k]) && m_pv[k]) begin
        m_aval[k] = m_pval[k]; m_amask[k] = m_pmask[k]; m_alz[k] = m_plz[k];
        m_pv[k] = 1'b0;
      end
      if (load) begin
        m_pval[k] = value; m_pmask[k] = mask; m_plz[k] = lz; m_pv[k] = 1'b1;
      end
    end
  endtask

  task automatic check(input int k);
    int         g, t, d;
    bit         show, blank;
    logic [3:0] e_dig, e_hex, o_dig, o_hex;
    logic       e_frm, o_frm;
    g = gap_of(k);
    t = m_t[k];
    o_dig = (k == 0) ? dig_g : dig_z;
    o_hex = (k == 0) ? hex_g : hex_z;
    o_frm = (k == 0) ? frm_g : frm_z;
    show  = is_show(g, t);
    e_dig = 4'hF;
    e_hex = 4'hF;
    if (show) begin
      d = digit_of(g, t);
      blank = m_amask[k][d] || (m_alz[k] && d > 0 && (m_aval[k] >> (4 * d)) == 16'h0);
      e_hex = ~m_aval[k][4*d +: 4];
      if (!blank) e_dig = ~(4'b0001 << d);
    end
    e_frm = frame_at(g, t);
    n_cmp++;
    assert (o_dig === e_dig) else begin
      n_fail++;
      $error("FAIL digit_n build%0d t=%0d observed %b expected %b", k, t, o_dig, e_dig);
    end
    n_cmp++;
    assert (o_frm === e_frm) else begin
      n_fail++;
      $error("FAIL frame build%0d t=%0d observed %b expected %b", k, t, o_frm, e_frm);
    end
    if (show || t == 0) begin
      n_cmp++;
      assert (o_hex === e_hex) else begin
        n_fail++;
        $error("FAIL hex_n build%0d t=%0d observed %h expected %h", k, t, o_hex, e_hex);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check(0);
    check(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic l);
    value = v; mask = m; lz = l; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    bit reached;
    rst = 1'b1; load = 1'b0; value = '0; mask = '0; lz = 1'b0;
    run(2);
    rst = 1'b0;

    do_load(16'h1234, 4'b0000, 1'b0);
    run(40);

    // Land a LOAD on the second cycle of digit 1's slot in the gap build.
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (is_show(1, m_t[0]) && digit_of(1, m_t[0]) == 1 && (m_t[0] % (ON + 1)) == 2)
        reached = 1'b1;
      else
        cycle();
    end
    n_cmp++;
    assert (reached) else begin
      n_fail++;
      $error("FAIL seek_digit1 observed %0d expected %0d", reached, 1);
    end
    do_load(16'hABCD, 4'b0000, 1'b0);
    run(24);

    do_load(16'h0005, 4'b0000, 1'b1);
    run(34);
    do_load(16'h0000, 4'b0000, 1'b1);
    run(20);
    do_load(16'h8888, 4'b0100, 1'b0);
    run(34);

    // Reset in the middle of a lit slot.
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (is_show(1, m_t[0]) && (m_t[0] % (ON + 1)) == 2) reached = 1'b1;
      else cycle();
    end
    n_cmp++;
    assert (reached) else begin
      n_fail++;
      $error("FAIL seek_midshow observed %0d expected %0d", reached, 1);
    end
    do_load(16'h4321, 4'b0000, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(20);

    // Randomized loads, occasional leading zeros, masks and resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        value = 16'($urandom) >> (4 * $urandom_range(0, 3));
        mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        lz    = 1'($urandom);
        load  = 1'b1;
      end
      cycle();
      load = 1'b0;
      rst  = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
